// File: rtl/color_sensor_emu.sv
// Emulated four-filter light-to-frequency sensor: synchronized pin decode, programmable
// per-filter half-periods, 50 % square wave. Optional LFSR jitter: COLOR_SENSOR_EMU_JITTER_EN.
module color_sensor_emu #(
  parameter int unsigned HP_WIDTH       = 16,
  parameter int unsigned RST_HALF_RED   = 5000,
  parameter int unsigned RST_HALF_BLUE  = 10000,
  parameter int unsigned RST_HALF_CLEAR = 2500,
  parameter int unsigned RST_HALF_GREEN = 8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s0,
  input  logic                s1,
  input  logic                s2,
  input  logic                s3,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [HP_WIDTH-1:0] cfg_data,
  output logic                sensor_out,
  output logic                running
);

  localparam int unsigned HW = HP_WIDTH + 6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [3:0]          pin_meta, pin_sync, pin_prev;  // {s0,s1,s2,s3}
  logic [HP_WIDTH-1:0] half_reg [4];
  logic [HW-1:0]       cnt, cnt_nxt, hcur, hcur_nxt;
  logic                out_nxt, run_nxt;

  logic [1:0]          filter_c;
  logic [5:0]          scale_c;
  logic [HP_WIDTH-1:0] half_cur_c, half_ld_c;
  logic [HW-1:0]       h_c, h_ld_c, h_tog_c;
  logic                idle_c, sel_change_c, cnt_last_c;

  // Pin synchronizer plus previous-cycle copy for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_meta <= 4'b0;
      pin_sync <= 4'b0;
      pin_prev <= 4'b0;
    end else begin
      pin_meta <= {s0, s1, s2, s3};
      pin_sync <= pin_meta;
      pin_prev <= pin_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_reg[0] <= HP_WIDTH'(RST_HALF_RED);
      half_reg[1] <= HP_WIDTH'(RST_HALF_BLUE);
      half_reg[2] <= HP_WIDTH'(RST_HALF_CLEAR);
      half_reg[3] <= HP_WIDTH'(RST_HALF_GREEN);
    end else if (cfg_we) begin
      half_reg[cfg_sel] <= cfg_data;
    end
  end

  assign filter_c = pin_sync[1:0];

  always_comb begin
    scale_c = 6'd0;
    case (pin_sync[3:2])
      2'b11:   scale_c = 6'd1;
      2'b10:   scale_c = 6'd5;
      2'b01:   scale_c = 6'd50;
      default: scale_c = 6'd0;
    endcase
  end

  // A restart coinciding with a write to the selected filter takes the written value
  assign half_cur_c   = half_reg[filter_c];
  assign half_ld_c    = (cfg_we && (cfg_sel == filter_c)) ? cfg_data : half_cur_c;
  assign h_c          = HW'(half_cur_c) * HW'(scale_c);
  assign h_ld_c       = HW'(half_ld_c) * HW'(scale_c);
  assign idle_c       = (scale_c == 6'd0) || (h_c == '0);
  assign sel_change_c = (pin_sync != pin_prev);
  assign cnt_last_c   = (cnt == hcur - HW'(1));

`ifdef COLOR_SENSOR_EMU_JITTER_EN
  logic [15:0] lfsr;
  logic        lfsr_step_c;

  assign lfsr_step_c = (state == ST_RUN) && !idle_c && !sel_change_c && cnt_last_c;
  assign h_tog_c     = h_c + HW'(lfsr[1:0]);

  // Fibonacci LFSR, taps 16,14,13,11; advances once per output toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (lfsr_step_c) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign h_tog_c = h_c;
`endif

  // Generator next-state: idle beats restart beats toggle beats count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcur_nxt  = hcur;
    out_nxt   = sensor_out;
    run_nxt   = running;
    if (idle_c) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      out_nxt   = 1'b0;
      run_nxt   = 1'b0;
    end else if ((state == ST_IDLE) || sel_change_c) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      hcur_nxt  = h_ld_c;
      out_nxt   = 1'b0;
      run_nxt   = 1'b1;
    end else if (cnt_last_c) begin
      cnt_nxt   = '0;
      hcur_nxt  = h_tog_c;
      out_nxt   = ~sensor_out;
    end else begin
      cnt_nxt   = cnt + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hcur       <= '0;
      sensor_out <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hcur       <= hcur_nxt;
      sensor_out <= out_nxt;
      running    <= run_nxt;
    end
  end

endmodule

// File: tb/tb_color_sensor_emu.sv
// Directed bench for color_sensor_emu (default build, no jitter): waveform timing per
// filter/scale, mid-level writes, power-down, write bypass and mid-level reset.
module tb_color_sensor_emu;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0, s1, s2, s3;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        sensor_out, running;

  int total = 0;
  int bad   = 0;

  localparam int BUDGET = 30000;

  color_sensor_emu dut (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .sensor_out(sensor_out), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  pins;   // {s0,s1,s2,s3}
    int          rise;   // edges from pin drive to first rise = H + 3
    int          high;
    int          low;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [3:0] p);
    {s0, s1, s2, s3} = p;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  // Edges until the first rise following the restart (restart lands on edge 3)
  task automatic wait_rise(input int n0, output int n);
    n = n0;
    while (n < BUDGET) begin
      step();
      n++;
      if (n >= 3 && sensor_out) break;
    end
  endtask

  // Edges until sensor_out leaves the given level
  task automatic measure(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sensor_out == lvl && n < BUDGET);
  endtask

  initial begin
    int n;

    vecs[0] = '{"red_x1",    1'b0, 2'd0, 16'd0,   4'b1100, 5003, 5000, 5000};
    vecs[1] = '{"red_x5",    1'b1, 2'd0, 16'd200, 4'b1000, 1003, 1000, 1000};
    vecs[2] = '{"red_x50",   1'b1, 2'd0, 16'd20,  4'b0100, 1003, 1000, 1000};
    vecs[3] = '{"blue_x1",   1'b1, 2'd1, 16'd100, 4'b1101, 103,  100,  100};
    vecs[4] = '{"clear_x1",  1'b0, 2'd0, 16'd0,   4'b1110, 2503, 2500, 2500};
    vecs[5] = '{"green_x5",  1'b1, 2'd3, 16'd7,   4'b1011, 38,   35,   35};
    vecs[6] = '{"clear_h1",  1'b1, 2'd2, 16'd1,   4'b1110, 4,    1,    1};

    reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 16'd0;
    set_pins(4'b0000);
    step(); step();
    reset = 1'b0;
    step(); step();
    check("reset_out", 64'(sensor_out), 0);
    check("reset_running", 64'(running), 0);

    foreach (vecs[i]) begin
      if (vecs[i].we) write_reg(vecs[i].sel, vecs[i].data);
      set_pins(vecs[i].pins);
      wait_rise(0, n);
      check({vecs[i].name, "_rise"}, n, vecs[i].rise);
      check({vecs[i].name, "_running"}, 64'(running), 1);
      measure(1'b1, n);
      check({vecs[i].name, "_high"}, n, vecs[i].high);
      measure(1'b0, n);
      check({vecs[i].name, "_low"}, n, vecs[i].low);
    end

    // Mid-level write to the active filter does not truncate the current level
    set_pins(4'b1101);
    wait_rise(0, n);
    check("midwr_rise", n, 103);
    write_reg(2'd1, 16'd40);
    measure(1'b1, n);
    check("midwr_high_rest", n, 99);
    measure(1'b0, n);
    check("midwr_low", n, 40);
    measure(1'b1, n);
    check("midwr_high", n, 40);
    measure(1'b0, n);
    check("midwr_low2", n, 40);

    // Power-down during a high level
    set_pins(4'b0000);
    step(); step();
    check("pd_out_e2", 64'(sensor_out), 1);
    check("pd_run_e2", 64'(running), 1);
    step();
    check("pd_out_e3", 64'(sensor_out), 0);
    check("pd_run_e3", 64'(running), 0);

    // Zero half-period stays idle
    write_reg(2'd2, 16'd0);
    set_pins(4'b1110);
    repeat (10) step();
    check("zero_out", 64'(sensor_out), 0);
    check("zero_running", 64'(running), 0);

    // Write coinciding with the restart is bypassed into the first level
    set_pins(4'b1101);
    step(); step();
    write_reg(2'd1, 16'd300);
    check("bypass_running", 64'(running), 1);
    wait_rise(3, n);
    check("bypass_rise", n, 303);
    measure(1'b1, n);
    check("bypass_high", n, 300);

    // Reset mid-level with green active; green register returns to 8000
    set_pins(4'b1111);
    wait_rise(0, n);
    check("green_rise", n, 10);
    step(); step();
    reset = 1'b1;
    step();
    check("rst_mid_out", 64'(sensor_out), 0);
    check("rst_mid_running", 64'(running), 0);
    reset = 1'b0;
    wait_rise(0, n);
    check("green_rst_rise", n, 8003);
    measure(1'b1, n);
    check("green_rst_high", n, 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
